execute_stage: RTL and testbench

//  Y86-64 execute (E) stage: selects ALU operands and function from icode/ifun, computes valE,

---
 rtl/y86_pkg.sv | 55 +++++
 rtl/execute_stage_alu.sv | 55 +++++
 rtl/execute_stage.sv | 204 ++++++++++++++++++++
 tb/tb_execute_stage.sv | 336 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/y86_pkg.sv
// Shared Y86-64 definitions: instruction codes, ALU operations, condition
// codes, the default stack step and the branch/move condition evaluator.
package y86_pkg;

  // Instruction codes
  localparam logic [3:0] I_HALT   = 4'h0;
  localparam logic [3:0] I_NOP    = 4'h1;
  localparam logic [3:0] I_RRMOVQ = 4'h2;
  localparam logic [3:0] I_IRMOVQ = 4'h3;
  localparam logic [3:0] I_RMMOVQ = 4'h4;
  localparam logic [3:0] I_MRMOVQ = 4'h5;
  localparam logic [3:0] I_OPQ    = 4'h6;
  localparam logic [3:0] I_JXX    = 4'h7;
  localparam logic [3:0] I_CALL   = 4'h8;
  localparam logic [3:0] I_RET    = 4'h9;
  localparam logic [3:0] I_PUSHQ  = 4'hA;
  localparam logic [3:0] I_POPQ   = 4'hB;

  // ALU operations; encoding matches the OPq ifun field
  typedef enum logic [1:0] {
    ALU_ADD = 2'd0,
    ALU_SUB = 2'd1,
    ALU_AND = 2'd2,
    ALU_XOR = 2'd3
  } alu_op_e;

  // Condition codes carried in ifun of jXX / cmovXX
  localparam logic [3:0] C_ALWAYS = 4'h0;
  localparam logic [3:0] C_LE     = 4'h1;
  localparam logic [3:0] C_L      = 4'h2;
  localparam logic [3:0] C_E      = 4'h3;
  localparam logic [3:0] C_NE     = 4'h4;
  localparam logic [3:0] C_GE     = 4'h5;
  localparam logic [3:0] C_G      = 4'h6;

  localparam int STK_STEP_DEF = 8;

  // Evaluate a condition against the flags; unknown codes evaluate false
  function automatic logic cond_eval(input logic [3:0] fn, input logic zf,
                                     input logic sf, input logic of);
    logic res;
    case (fn)
      C_ALWAYS: res = 1'b1;
      C_LE:     res = (sf ^ of) | zf;
      C_L:      res = sf ^ of;
      C_E:      res = zf;
      C_NE:     res = ~zf;
      C_GE:     res = ~(sf ^ of);
      C_G:      res = ~(sf ^ of) & ~zf;
      default:  res = 1'b0;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/execute_stage_alu.sv
// Combinational ALU: res = b OP a with two's-complement wrap, plus the
// zero/sign/overflow flags of the result. Subtraction is b - a.
module alu_64
  import y86_pkg::*;
#(
  parameter int WIDTH = 64
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  alu_op_e          op_i,
  output logic [WIDTH-1:0] res_o,
  output logic             zf_o,
  output logic             sf_o,
  output logic             of_o
);

  localparam int MSB = WIDTH - 1;

  logic [WIDTH-1:0] res_s;
  logic             of_s;

  // Select the operation and derive signed overflow from operand/result signs
  always_comb begin
    res_s = '0;
    of_s  = 1'b0;
    case (op_i)
      ALU_ADD: begin
        res_s = b_i + a_i;
        of_s  = (a_i[MSB] == b_i[MSB]) & (res_s[MSB] != a_i[MSB]);
      end
      ALU_SUB: begin
        res_s = b_i - a_i;
        of_s  = (a_i[MSB] != b_i[MSB]) & (res_s[MSB] != b_i[MSB]);
      end
      ALU_AND: begin
        res_s = b_i & a_i;
        of_s  = 1'b0;
      end
      ALU_XOR: begin
        res_s = b_i ^ a_i;
        of_s  = 1'b0;
      end
      default: begin
        res_s = '0;
        of_s  = 1'b0;
      end
    endcase
  end

  assign res_o = res_s;
  assign zf_o  = (res_s == '0);
  assign sf_o  = res_s[MSB];
  assign of_o  = of_s;

endmodule

// File: rtl/execute_stage.sv
// Y86-64 execute stage: operand/function selection, condition-code register,
// Cnd evaluation and a single-entry valid/ready E/M output register.
module execute_stage
  import y86_pkg::*;
#(
  parameter int WIDTH    = 64,
  parameter int STK_STEP = STK_STEP_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       icode,
  input  logic [3:0]       ifun,
  input  logic [WIDTH-1:0] val_a,
  input  logic [WIDTH-1:0] val_b,
  input  logic [WIDTH-1:0] val_c,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [3:0]       out_icode,
  output logic [WIDTH-1:0] out_val_e,
  output logic [WIDTH-1:0] out_val_a,
  output logic             out_cnd,
  output logic             out_err,
  output logic             cc_zf,
  output logic             cc_sf,
  output logic             cc_of
);

  localparam logic [WIDTH-1:0] STK_STEP_W = WIDTH'(STK_STEP);

  // E/M register and condition codes
  logic             valid_q, valid_d;
  logic [3:0]       icode_q, icode_d;
  logic [WIDTH-1:0] val_e_q, val_e_d;
  logic [WIDTH-1:0] val_a_q, val_a_d;
  logic             cnd_q, cnd_d;
  logic             err_q, err_d;
  logic             zf_q, zf_d;
  logic             sf_q, sf_d;
  logic             of_q, of_d;

  // Decode results
  logic [WIDTH-1:0] alu_a_s;
  logic [WIDTH-1:0] alu_b_s;
  alu_op_e          alu_op_s;
  logic             set_cc_s;
  logic             err_s;
  logic             cnd_s;
  logic             accept_s;

  // ALU results
  logic [WIDTH-1:0] alu_res_s;
  logic             alu_zf_s;
  logic             alu_sf_s;
  logic             alu_of_s;

  assign in_ready = ~valid_q | out_ready;
  assign accept_s = in_valid & in_ready;

  // Map icode/ifun onto ALU operands and function, error flag and Cnd
  always_comb begin
    alu_a_s  = '0;
    alu_b_s  = '0;
    alu_op_s = ALU_ADD;
    set_cc_s = 1'b0;
    err_s    = 1'b0;
    cnd_s    = 1'b0;
    case (icode)
      I_HALT, I_NOP: begin
        alu_a_s = '0;
      end
      I_RRMOVQ: begin
        alu_a_s = val_a;
        if (ifun <= C_G) begin
          cnd_s = cond_eval(ifun, zf_q, sf_q, of_q);
        end else begin
          err_s = 1'b1;
        end
      end
      I_IRMOVQ: begin
        alu_a_s = val_c;
      end
      I_RMMOVQ, I_MRMOVQ: begin
        alu_a_s = val_c;
        alu_b_s = val_b;
      end
      I_OPQ: begin
        if (ifun <= 4'h3) begin
          alu_a_s  = val_a;
          alu_b_s  = val_b;
          alu_op_s = alu_op_e'(ifun[1:0]);
          set_cc_s = 1'b1;
        end else begin
          err_s = 1'b1;
        end
      end
      I_JXX: begin
        if (ifun <= C_G) begin
          cnd_s = cond_eval(ifun, zf_q, sf_q, of_q);
        end else begin
          err_s = 1'b1;
        end
      end
      I_CALL, I_PUSHQ: begin
        alu_a_s  = STK_STEP_W;
        alu_b_s  = val_b;
        alu_op_s = ALU_SUB;
      end
      I_RET, I_POPQ: begin
        alu_a_s  = STK_STEP_W;
        alu_b_s  = val_b;
        alu_op_s = ALU_ADD;
      end
      default: begin
        err_s = 1'b1;
      end
    endcase
  end

  alu_64 #(.WIDTH(WIDTH)) u_alu (
    .a_i  (alu_a_s),
    .b_i  (alu_b_s),
    .op_i (alu_op_s),
    .res_o(alu_res_s),
    .zf_o (alu_zf_s),
    .sf_o (alu_sf_s),
    .of_o (alu_of_s)
  );

  // Next state of the E/M register: load on accept, drain on consume, else hold
  always_comb begin
    valid_d = valid_q;
    icode_d = icode_q;
    val_e_d = val_e_q;
    val_a_d = val_a_q;
    cnd_d   = cnd_q;
    err_d   = err_q;
    if (accept_s) begin
      valid_d = 1'b1;
      icode_d = icode;
      val_e_d = alu_res_s;
      val_a_d = val_a;
      cnd_d   = cnd_s;
      err_d   = err_s;
    end else if (out_ready) begin
      valid_d = 1'b0;
    end else begin
      valid_d = valid_q;
    end
  end

  // Next condition codes: only an accepted, well-formed OPq updates them
  always_comb begin
    zf_d = zf_q;
    sf_d = sf_q;
    of_d = of_q;
    if (accept_s && set_cc_s) begin
      zf_d = alu_zf_s;
      sf_d = alu_sf_s;
      of_d = alu_of_s;
    end else begin
      zf_d = zf_q;
      sf_d = sf_q;
      of_d = of_q;
    end
  end

  // State registers; reset dominates any concurrent accept
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      icode_q <= 4'h0;
      val_e_q <= '0;
      val_a_q <= '0;
      cnd_q   <= 1'b0;
      err_q   <= 1'b0;
      zf_q    <= 1'b1;
      sf_q    <= 1'b0;
      of_q    <= 1'b0;
    end else begin
      valid_q <= valid_d;
      icode_q <= icode_d;
      val_e_q <= val_e_d;
      val_a_q <= val_a_d;
      cnd_q   <= cnd_d;
      err_q   <= err_d;
      zf_q    <= zf_d;
      sf_q    <= sf_d;
      of_q    <= of_d;
    end
  end

  assign out_valid = valid_q;
  assign out_icode = icode_q;
  assign out_val_e = val_e_q;
  assign out_val_a = val_a_q;
  assign out_cnd   = cnd_q;
  assign out_err   = err_q;
  assign cc_zf     = zf_q;
  assign cc_sf     = sf_q;
  assign cc_of     = of_q;

endmodule

// File: tb/tb_execute_stage.sv
// Scoreboard bench for execute_stage: directed scenarios followed by random
// traffic with random backpressure, checked against an arithmetic reference.
module tb_execute_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  icode;
  logic [3:0]  ifun;
  logic [63:0] val_a, val_b, val_c;
  logic        out_valid;
  logic        out_ready;
  logic [3:0]  out_icode;
  logic [63:0] out_val_e, out_val_a;
  logic        out_cnd, out_err;
  logic        cc_zf, cc_sf, cc_of;

  always #5 clk = ~clk;

  execute_stage #(.WIDTH(64), .STK_STEP(8)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .icode(icode), .ifun(ifun), .val_a(val_a), .val_b(val_b), .val_c(val_c),
    .out_valid(out_valid), .out_ready(out_ready), .out_icode(out_icode),
    .out_val_e(out_val_e), .out_val_a(out_val_a), .out_cnd(out_cnd),
    .out_err(out_err), .cc_zf(cc_zf), .cc_sf(cc_sf), .cc_of(cc_of)
  );

  typedef struct packed {
    logic [3:0]  icode;
    logic [63:0] val_e;
    logic [63:0] val_a;
    logic        cnd;
    logic        err;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_errors = 0;
  bit   m_zf = 1'b1, m_sf = 1'b0, m_of = 1'b0;
  bit   acc_seen = 1'b0;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  function automatic bit cond_ref(input logic [3:0] fn, input bit zf, input bit sf, input bit of);
    case (fn)
      4'd0: return 1'b1;
      4'd1: return (sf != of) || zf;
      4'd2: return sf != of;
      4'd3: return zf;
      4'd4: return !zf;
      4'd5: return sf == of;
      4'd6: return (sf == of) && !zf;
      default: return 1'b0;
    endcase
  endfunction

  // Reference: what the stage should emit and how the flags should move
  task automatic ref_model(input logic [3:0] ic, input logic [3:0] fn,
                           input logic [63:0] a, input logic [63:0] b, input logic [63:0] c,
                           output exp_t e);
    logic [63:0] r;
    logic signed [127:0] sa, sb, ex;
    r = 64'd0;
    e.cnd = 1'b0;
    e.err = 1'b0;
    case (ic)
      4'h6: begin
        if (fn <= 4'd3) begin
          sa = {{64{a[63]}}, a};
          sb = {{64{b[63]}}, b};
          ex = 128'sd0;
          case (fn)
            4'd0: begin r = b + a; ex = sb + sa; end
            4'd1: begin r = b - a; ex = sb - sa; end
            4'd2: r = b & a;
            default: r = b ^ a;
          endcase
          m_zf = (r == 64'd0);
          m_sf = ($signed(r) < 0);
          m_of = (fn <= 4'd1) ? (ex != {{64{r[63]}}, r}) : 1'b0;
        end else begin
          e.err = 1'b1;
        end
      end
      4'h2, 4'h7: begin
        r = (ic == 4'h2) ? a : 64'd0;
        if (fn <= 4'd6) e.cnd = cond_ref(fn, m_zf, m_sf, m_of);
        else e.err = 1'b1;
      end
      4'h3: r = c;
      4'h4, 4'h5: r = b + c;
      4'h8, 4'hA: r = b - 64'd8;
      4'h9, 4'hB: r = b + 64'd8;
      4'h0, 4'h1: r = 64'd0;
      default: e.err = 1'b1;
    endcase
    e.icode = ic;
    e.val_e = r;
    e.val_a = a;
  endtask

  // Issue side: track accepts, predict results, check flags and in_ready
  initial forever begin
    exp_t e;
    @(negedge clk);
    acc_seen = 1'b0;
    if (!rst_n) begin
      sb_q.delete();
      m_zf = 1'b1; m_sf = 1'b0; m_of = 1'b0;
    end else begin
      chk("cc", {61'd0, cc_zf, cc_sf, cc_of}, {61'd0, m_zf, m_sf, m_of});
      chk("in_ready", {63'd0, in_ready}, {63'd0, (!out_valid) || out_ready});
      if (in_valid && in_ready) begin
        ref_model(icode, ifun, val_a, val_b, val_c, e);
        sb_q.push_back(e);
        acc_seen = 1'b1;
      end
    end
  end

  // Output side: pop and compare on every handshake, check held outputs
  initial begin
    exp_t cur, prev, e;
    bit   hold;
    hold = 1'b0;
    prev = '0;
    forever begin
      @(negedge clk);
      cur = '{out_icode, out_val_e, out_val_a, out_cnd, out_err};
      if (rst_n) begin
        if (hold) begin
          chk("hold_valid", {63'd0, out_valid}, 64'd1);
          n_checks++;
          if (cur !== prev) begin
            n_errors++;
            $display("FAIL hold: got %h expected %h", cur, prev);
          end
        end
        if (out_valid && out_ready) begin
          n_checks++;
          if (sb_q.size() == 0) begin
            n_errors++;
            $display("FAIL unexpected_output: got %h expected none", cur);
          end else begin
            e = sb_q.pop_front();
            if (cur !== e) begin
              n_errors++;
              $display("FAIL scoreboard: got ic=%h ve=%h va=%h cnd=%b err=%b expected ic=%h ve=%h va=%h cnd=%b err=%b",
                       cur.icode, cur.val_e, cur.val_a, cur.cnd, cur.err,
                       e.icode, e.val_e, e.val_a, e.cnd, e.err);
            end
          end
        end
        hold = out_valid && !out_ready;
        prev = cur;
      end else begin
        hold = 1'b0;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic look();
    @(negedge clk);
  endtask

  task automatic send(input logic [3:0] ic, input logic [3:0] fn,
                      input logic [63:0] a, input logic [63:0] b, input logic [63:0] c);
    int n;
    step();
    in_valid = 1'b1; icode = ic; ifun = fn; val_a = a; val_b = b; val_c = c;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 100) begin
      n++;
      @(negedge clk);
    end
    if (!in_ready) begin
      n_checks++;
      n_errors++;
      $display("FAIL send_timeout: got in_ready=0 expected 1");
    end
    step();
    in_valid = 1'b0;
  endtask

  function automatic logic [63:0] rnd64();
    case ($urandom_range(0, 5))
      0: return 64'd0;
      1: return 64'h7FFF_FFFF_FFFF_FFFF;
      2: return 64'h8000_0000_0000_0000;
      3: return 64'hFFFF_FFFF_FFFF_FFFF;
      default: return {$urandom, $urandom};
    endcase
  endfunction

  initial begin
    logic [63:0] ve_hold;
    logic [2:0]  cc_hold;
    int          r;
    rst_n = 1'b0; in_valid = 1'b1; icode = 4'h6; ifun = 4'h0;
    val_a = 64'd1; val_b = 64'd2; val_c = 64'd0; out_ready = 1'b1;

    // Reset with in_valid asserted
    repeat (3) @(posedge clk);
    look();
    chk("rst_valid", {63'd0, out_valid}, 64'd0);
    chk("rst_zf", {63'd0, cc_zf}, 64'd1);
    chk("rst_sf", {63'd0, cc_sf}, 64'd0);
    chk("rst_of", {63'd0, cc_of}, 64'd0);
    chk("rst_val_e", out_val_e, 64'd0);
    chk("rst_err", {63'd0, out_err}, 64'd0);
    step();
    rst_n = 1'b1; in_valid = 1'b0;

    // XOR and zero flag
    send(4'h6, 4'h3, 64'h26, 64'h31, 64'd0); look();
    chk("xor_val", out_val_e, 64'h17);
    chk("xor_zf", {63'd0, cc_zf}, 64'd0);
    chk("xor_sf", {63'd0, cc_sf}, 64'd0);
    send(4'h6, 4'h3, 64'h5, 64'h5, 64'd0); look();
    chk("xor0_val", out_val_e, 64'd0);
    chk("xor0_zf", {63'd0, cc_zf}, 64'd1);

    // Signed overflow on add, then conditions against those flags
    send(4'h6, 4'h0, 64'h7FFF_FFFF_FFFF_FFFF, 64'h7FFF_FFFF_FFFF_FFFF, 64'd0); look();
    chk("add_val", out_val_e, 64'hFFFF_FFFF_FFFF_FFFE);
    chk("add_sf", {63'd0, cc_sf}, 64'd1);
    chk("add_of", {63'd0, cc_of}, 64'd1);
    send(4'h2, 4'h2, 64'h55, 64'd0, 64'd0); look();
    chk("cmovl_cnd", {63'd0, out_cnd}, 64'd0);
    chk("cmovl_val", out_val_e, 64'h55);
    send(4'h7, 4'h6, 64'd0, 64'd0, 64'd0); look();
    chk("jg_cnd", {63'd0, out_cnd}, 64'd1);
    send(4'h7, 4'h4, 64'd0, 64'd0, 64'd0); look();
    chk("jne_cnd", {63'd0, out_cnd}, 64'd1);

    // Negative subtraction result, jl, invalid condition code
    send(4'h6, 4'h1, 64'd5, 64'd3, 64'd0); look();
    chk("sub_val", out_val_e, 64'hFFFF_FFFF_FFFF_FFFE);
    chk("sub_sf", {63'd0, cc_sf}, 64'd1);
    chk("sub_of", {63'd0, cc_of}, 64'd0);
    send(4'h7, 4'h2, 64'd0, 64'd0, 64'd0); look();
    chk("jl_cnd", {63'd0, out_cnd}, 64'd1);
    send(4'h7, 4'h7, 64'd0, 64'd0, 64'd0); look();
    chk("j7_err", {63'd0, out_err}, 64'd1);
    chk("j7_cnd", {63'd0, out_cnd}, 64'd0);

    // Backpressure: result held, next instruction waits
    step(); out_ready = 1'b0;
    send(4'h6, 4'h0, 64'd1, 64'd2, 64'd0); look();
    ve_hold = out_val_e;
    cc_hold = {cc_zf, cc_sf, cc_of};
    chk("bp_val", ve_hold, 64'd3);
    step();
    in_valid = 1'b1; icode = 4'h6; ifun = 4'h1; val_a = 64'd10; val_b = 64'd3;
    for (int i = 0; i < 4; i++) begin
      look();
      chk("bp_in_ready", {63'd0, in_ready}, 64'd0);
      chk("bp_val_held", out_val_e, ve_hold);
      chk("bp_cc_held", {61'd0, cc_zf, cc_sf, cc_of}, {61'd0, cc_hold});
      step();
    end
    out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    look();
    chk("bp_next_val", out_val_e, 64'hFFFF_FFFF_FFFF_FFF9);

    // Stack adjust and undefined icode
    send(4'hA, 4'h0, 64'd0, 64'h100, 64'd0); look();
    chk("push_val", out_val_e, 64'hF8);
    send(4'hB, 4'h0, 64'd0, 64'h100, 64'd0); look();
    chk("pop_val", out_val_e, 64'h108);
    cc_hold = {cc_zf, cc_sf, cc_of};
    send(4'hC, 4'h0, 64'd0, 64'd0, 64'd0); look();
    chk("bad_err", {63'd0, out_err}, 64'd1);
    chk("bad_cc", {61'd0, cc_zf, cc_sf, cc_of}, {61'd0, cc_hold});

    // Reset drops a stalled result
    step(); out_ready = 1'b0;
    send(4'h6, 4'h2, 64'hF0, 64'hFF, 64'd0); look();
    chk("inflight_valid", {63'd0, out_valid}, 64'd1);
    step(); rst_n = 1'b0;
    step(); rst_n = 1'b1; out_ready = 1'b1;
    look();
    chk("rst2_valid", {63'd0, out_valid}, 64'd0);
    chk("rst2_zf", {63'd0, cc_zf}, 64'd1);

    // Random traffic with random backpressure
    for (int cyc = 0; cyc < 600; cyc++) begin
      step();
      out_ready = ($urandom_range(0, 3) != 0);
      if (!in_valid || acc_seen) begin
        if ($urandom_range(0, 9) < 7) begin
          in_valid = 1'b1;
          r = $urandom_range(0, 9);
          if (r < 3) icode = 4'h6;
          else if (r < 5) icode = (r == 3) ? 4'h7 : 4'h2;
          else icode = 4'($urandom_range(0, 15));
          ifun  = (icode == 4'h6) ? 4'($urandom_range(0, 4)) : 4'($urandom_range(0, 7));
          val_a = rnd64();
          val_b = rnd64();
          val_c = rnd64();
        end else begin
          in_valid = 1'b0;
        end
      end
    end

    // Drain
    step();
    in_valid = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < 50; i++) begin
      if (sb_q.size() == 0) break;
      step();
    end
    look();
    chk("drain_empty", 64'(sb_q.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
